// File: rtl/serv_mtimer_pkg.sv
// Shared definitions for the machine timer: register map, CTRL field
// positions and the byte-lane merge used by every writable register.
package serv_mtimer_pkg;

  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CTRL     = 3'd4
  } reg_addr_e;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/serv_mtimer_if.sv
// Wishbone-classic data bus between the core's dbus initiator and the timer.
interface serv_mtimer_if;

  logic        i_wb_cyc;
  logic        i_wb_we;
  logic [2:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_cyc, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_cyc, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
    output o_wb_rdt, o_wb_ack
  );

endinterface

// File: rtl/serv_mtimer_prescaler.sv
// Clock divider for mtime: one tick every div+1 enabled clocks.
// The tick is combinational from the current count so the counter and the
// mtime increment it drives land on the same edge.
module serv_mtimer_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  clr,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = en && (cnt == div);

  // Count while enabled, wrap at div, restart from zero on a CTRL write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == div) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serv_mtimer.sv
// RISC-V machine timer on the dbus: mtime/mtimecmp register file with a
// single-cycle ack, prescaled free-running counter and a level timer irq.
module serv_mtimer
  import serv_mtimer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 8,
  parameter int unsigned RESET_DIV  = 0,
  parameter bit          RESET_EN   = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  serv_mtimer_if.slave wb,
  output logic         o_timer_irq
);

  localparam logic [31:0] CTRL_MASK =
    (((32'd1 << PRESCALE_W) - 32'd1) << CTRL_DIV_LSB) | (32'd1 << CTRL_EN_BIT);
  localparam logic [31:0] CTRL_RESET =
    ((32'(RESET_DIV) << CTRL_DIV_LSB) | (32'(RESET_EN) << CTRL_EN_BIT)) & CTRL_MASK;

  logic        access;
  logic        wr_en;
  logic        rd_en;
  logic        ctrl_wr;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] hi_shadow;
  logic [31:0] ctrl_q;
  logic [31:0] rd_data;
  logic [31:0] wr_old;
  logic [31:0] wr_merged;

  assign access  = wb.i_wb_cyc & ~wb.o_wb_ack;
  assign wr_en   = access & wb.i_wb_we;
  assign rd_en   = access & ~wb.i_wb_we;
  assign ctrl_wr = wr_en && (wb.i_wb_adr == REG_CTRL);

  serv_mtimer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (ctrl_q[CTRL_EN_BIT]),
    .div   (ctrl_q[CTRL_DIV_LSB +: PRESCALE_W]),
    .clr   (ctrl_wr),
    .tick  (tick)
  );

  // Address decode: read mux (MTIME_HI comes from the shadow) and the
  // pre-write word that unselected byte lanes keep.
  always_comb begin
    rd_data = '0;
    wr_old  = '0;
    case (wb.i_wb_adr)
      REG_MTIME_LO: begin rd_data = mtime[31:0];     wr_old = mtime[31:0];     end
      REG_MTIME_HI: begin rd_data = hi_shadow;       wr_old = mtime[63:32];    end
      REG_CMP_LO:   begin rd_data = mtimecmp[31:0];  wr_old = mtimecmp[31:0];  end
      REG_CMP_HI:   begin rd_data = mtimecmp[63:32]; wr_old = mtimecmp[63:32]; end
      REG_CTRL:     begin rd_data = ctrl_q;          wr_old = ctrl_q;          end
      default:      begin rd_data = '0;              wr_old = '0;              end
    endcase
    wr_merged = merge_lanes(wr_old, wb.i_wb_dat, wb.i_wb_sel);
  end

  // Bus response: ack one cycle after cyc, read data and the coherent
  // high-word snapshot taken whenever the low word is read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wb.o_wb_ack <= 1'b0;
      wb.o_wb_rdt <= '0;
      hi_shadow   <= '0;
    end else begin
      wb.o_wb_ack <= access;
      wb.o_wb_rdt <= rd_en ? rd_data : '0;
      if (rd_en && (wb.i_wb_adr == REG_MTIME_LO)) hi_shadow <= mtime[63:32];
    end
  end

  // mtime: a bus write to either half wins over the tick, and the tick is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mtime <= '0;
    end else if (wr_en && (wb.i_wb_adr == REG_MTIME_LO)) begin
      mtime[31:0] <= wr_merged;
    end else if (wr_en && (wb.i_wb_adr == REG_MTIME_HI)) begin
      mtime[63:32] <= wr_merged;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp: byte-lane writable, resets to all-ones so the irq stays quiet.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mtimecmp <= '1;
    end else if (wr_en && (wb.i_wb_adr == REG_CMP_LO)) begin
      mtimecmp[31:0] <= wr_merged;
    end else if (wr_en && (wb.i_wb_adr == REG_CMP_HI)) begin
      mtimecmp[63:32] <= wr_merged;
    end
  end

  // CTRL: only the enable bit and divisor field are storable.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ctrl_q <= CTRL_RESET;
    end else if (ctrl_wr) begin
      ctrl_q <= wr_merged & CTRL_MASK;
    end
  end

  // Timer interrupt: registered unsigned compare of the current register values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_timer_irq <= 1'b0;
    end else begin
      o_timer_irq <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_serv_mtimer.sv
// Directed bench for serv_mtimer. Read transactions push their expected
// data into a scoreboard; a negedge monitor pops and compares on every read ack.
module tb_serv_mtimer;
  import serv_mtimer_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic o_timer_irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  serv_mtimer_if bus ();

  serv_mtimer #(
    .PRESCALE_W (8),
    .RESET_DIV  (0),
    .RESET_EN   (1'b1)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .wb          (bus),
    .o_timer_irq (o_timer_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Scoreboard monitor: every read ack is compared against the oldest expectation.
  always @(negedge i_clk) begin
    if (i_rst_n && bus.o_wb_ack && !bus.i_wb_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_read_ack: got 0x%08h, expected no response", bus.o_wb_rdt);
      end else begin
        string       nm;
        logic [31:0] ex;
        nm = name_q.pop_front();
        ex = exp_q.pop_front();
        checkOutput(nm, bus.o_wb_rdt, ex);
      end
    end
  end

  // One bus transaction: cyc rises 1ns after an edge, the access commits on
  // the next edge, and cyc drops as soon as ack is seen.
  task automatic applyStimulus(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [31:0] exp, input string name);
    bit got_ack;
    got_ack = 1'b0;
    if (!we) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge i_clk); #1;
    bus.i_wb_cyc = 1'b1;
    bus.i_wb_we  = we;
    bus.i_wb_adr = adr;
    bus.i_wb_dat = dat;
    bus.i_wb_sel = sel;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(posedge i_clk); #1;
      if (bus.o_wb_ack) got_ack = 1'b1;
    end
    bus.i_wb_cyc = 1'b0;
    if (!got_ack) begin
      n_checks++;
      $display("[TB] FAIL %s_ack_timeout: got no ack, expected ack within 8 cycles", name);
    end
  endtask

  task automatic wrReg(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    applyStimulus(1'b1, adr, dat, sel, 32'h0, "write");
  endtask

  task automatic rdReg(input logic [2:0] adr, input logic [31:0] exp, input string name);
    applyStimulus(1'b0, adr, 32'h0, 4'hF, exp, name);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 50000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] ack_pat;
    ack_pat = 6'b101010;

    i_rst_n      = 1'b0;
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_we  = 1'b0;
    bus.i_wb_adr = 3'd0;
    bus.i_wb_dat = 32'h0;
    bus.i_wb_sel = 4'h0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Reset state, then free-running count at div=0
    checkOutput("rst_ack", 32'(bus.o_wb_ack), 32'd0);
    checkOutput("rst_irq", 32'(o_timer_irq), 32'd0);
    checkOutput("rst_rdt", bus.o_wb_rdt, 32'd0);
    repeat (9) @(posedge i_clk);
    rdReg(REG_MTIME_LO, 32'd10, "mtime_lo_after_reset");
    rdReg(REG_MTIME_HI, 32'd0, "mtime_hi_after_reset");
    rdReg(REG_CTRL, 32'h0000_0001, "ctrl_reset");

    // Divide by 4: mtime cleared, ticks every fourth edge after the CTRL write
    wrReg(REG_CTRL, 32'h0000_0301, 4'hF);
    wrReg(REG_MTIME_LO, 32'h0, 4'hF);
    repeat (20) @(posedge i_clk);
    rdReg(REG_MTIME_LO, 32'd5, "div4_first");
    rdReg(REG_MTIME_LO, 32'd6, "div4_second");
    wrReg(REG_CTRL, 32'h0000_0300, 4'hF);
    rdReg(REG_MTIME_LO, 32'd7, "frozen_a");
    repeat (20) @(posedge i_clk);
    rdReg(REG_MTIME_LO, 32'd7, "frozen_b");
    rdReg(REG_CTRL, 32'h0000_0300, "ctrl_readback");

    // Coherent 64-bit read across the low-word carry
    wrReg(REG_CTRL, 32'h0000_0001, 4'hF);
    wrReg(REG_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    rdReg(REG_MTIME_LO, 32'hFFFF_FFFF, "carry_lo");
    rdReg(REG_MTIME_HI, 32'h0, "carry_hi_shadow");
    rdReg(REG_MTIME_LO, 32'd3, "post_carry_lo");
    rdReg(REG_MTIME_HI, 32'd1, "post_carry_hi");

    // Compare at 50: irq rises one edge after mtime reaches 50
    wrReg(REG_CTRL, 32'h0, 4'hF);
    wrReg(REG_MTIME_HI, 32'h0, 4'hF);
    wrReg(REG_MTIME_LO, 32'h0, 4'hF);
    wrReg(REG_CMP_HI, 32'h0, 4'hF);
    wrReg(REG_CMP_LO, 32'd50, 4'hF);
    checkOutput("irq_before_run", 32'(o_timer_irq), 32'd0);
    wrReg(REG_CTRL, 32'h0000_0001, 4'hF);
    repeat (50) @(posedge i_clk); #1;
    checkOutput("irq_at_mtime_50", 32'(o_timer_irq), 32'd0);
    @(posedge i_clk); #1;
    checkOutput("irq_rise", 32'(o_timer_irq), 32'd1);
    wrReg(REG_CMP_LO, 32'hFFFF_FFFF, 4'hF);
    checkOutput("irq_held_at_ack", 32'(o_timer_irq), 32'd1);
    @(posedge i_clk); #1;
    checkOutput("irq_drop", 32'(o_timer_irq), 32'd0);

    // Byte-lane write and unmapped addresses
    wrReg(REG_CMP_LO, 32'hAABB_CCDD, 4'b0010);
    rdReg(REG_CMP_LO, 32'hFFFF_CCFF, "cmp_lo_lane1");
    rdReg(REG_CMP_HI, 32'h0, "cmp_hi");
    rdReg(3'd6, 32'h0, "unmapped6");
    wrReg(3'd5, 32'hDEAD_BEEF, 4'hF);
    rdReg(3'd5, 32'h0, "unmapped5_after_write");

    // cyc held for six cycles: ack toggles, never two in a row
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0);
      name_q.push_back("held_cyc_read");
    end
    @(posedge i_clk); #1;
    bus.i_wb_cyc = 1'b1;
    bus.i_wb_we  = 1'b0;
    bus.i_wb_adr = 3'd6;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge i_clk); #1;
      end
      checkOutput($sformatf("ack_pattern_%0d", i), 32'(bus.o_wb_ack), 32'(ack_pat[i]));
    end
    bus.i_wb_cyc = 1'b0;

    // Reset during a write: no ack and no commit
    @(posedge i_clk); #1;
    bus.i_wb_cyc = 1'b1;
    bus.i_wb_we  = 1'b1;
    bus.i_wb_adr = REG_CMP_LO;
    bus.i_wb_dat = 32'h1234_5678;
    bus.i_wb_sel = 4'hF;
    i_rst_n      = 1'b0;
    @(posedge i_clk); #1;
    checkOutput("rst_mid_write_ack", 32'(bus.o_wb_ack), 32'd0);
    bus.i_wb_cyc = 1'b0;
    i_rst_n      = 1'b1;
    rdReg(REG_CMP_LO, 32'hFFFF_FFFF, "no_commit_cmp_lo");
    rdReg(REG_CTRL, 32'h0000_0001, "ctrl_after_rst");
    checkOutput("irq_after_rst", 32'(o_timer_irq), 32'd0);

    repeat (3) @(posedge i_clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
